// File: rtl/sevenseg_pkg.sv
// Shared constants and glyph table for the seven-segment decoder.
// Optional feature macro: SEVENSEG_HEX_DIGITS_EN (codes 10-15 show A,b,C,d,E,F).
// All patterns here are active-low: bit = 0 means the segment is lit.
package sevenseg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [6:0] SEG_ALL = 7'h00;

  // Index 15 is the leftmost entry and index 0 the rightmost entry.
`ifdef SEVENSEG_HEX_DIGITS_EN
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08,
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
`else
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    SEG_OFF, SEG_OFF, SEG_OFF, SEG_OFF, SEG_OFF, SEG_OFF,
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
`endif

  // Active-low pattern for one 4-bit code; every code maps to a full glyph or blank.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    return GLYPH_TABLE[d];
  endfunction

endpackage

// File: rtl/sevenseg_glyph_rom.sv
// Combinational code-to-segment lookup, presented in the display's polarity.
// Honours SEVENSEG_HEX_DIGITS_EN through the shared glyph table.
module sevenseg_glyph_rom
  import sevenseg_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] bcd,
  output logic [6:0] pattern
);

  // Table is stored active-low; invert for active-high displays.
  always_comb begin
    pattern = glyph(bcd);
    if (!ACTIVE_LOW) pattern = ~glyph(bcd);
  end

endmodule

// File: rtl/sevenseg_decoder.sv
// Registered BCD to seven-segment decoder for one HEX display.
// Priority: lamp_test, then blank, then decoded digit; one clock of latency.
// Optional feature macro: SEVENSEG_HEX_DIGITS_EN (hex glyphs for 10-15, else blank).
module sevenseg_decoder
  import sevenseg_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       lamp_test,
  output logic [6:0] seg
);

  localparam logic [6:0] OFF_PAT = ACTIVE_LOW ? SEG_OFF : ~SEG_OFF;
  localparam logic [6:0] ALL_PAT = ACTIVE_LOW ? SEG_ALL : ~SEG_ALL;

  logic [6:0] glyph_p0;
  logic [6:0] seg_p0;
  logic [6:0] seg_p1;

  sevenseg_glyph_rom #(
    .ACTIVE_LOW(ACTIVE_LOW)
  ) u_rom (
    .bcd    (bcd),
    .pattern(glyph_p0)
  );

  // Stage p0: priority select between lamp test, blanking and the decoded glyph.
  always_comb begin
    seg_p0 = glyph_p0;
    if (lamp_test)  seg_p0 = ALL_PAT;
    else if (blank) seg_p0 = OFF_PAT;
  end

  // Stage p1: output register keeps segment lines glitch-free; reset blanks the display.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) seg_p1 <= OFF_PAT;
    else     seg_p1 <= seg_p0;
  end

  assign seg = seg_p1;

endmodule

// File: tb/tb_sevenseg_decoder.sv
// Randomised self-checking bench for sevenseg_decoder against a segment-name model.
module tb_sevenseg_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] bcd = 4'd0;
  logic       blank = 1'b0;
  logic       lamp_test = 1'b0;
  logic [6:0] seg_al;
  logic [6:0] seg_ah;

  logic [3:0] sw_bcd [6];
  logic [6:0] sw_seg [6];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sevenseg_decoder #(.ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst(rst), .bcd(bcd), .blank(blank), .lamp_test(lamp_test), .seg(seg_al)
  );

  sevenseg_decoder #(.ACTIVE_LOW(1'b0)) dut_ah (
    .clk(clk), .rst(rst), .bcd(bcd), .blank(blank), .lamp_test(lamp_test), .seg(seg_ah)
  );

  // Stopwatch digits: mm:ss.cc, index 0 = minutes high ... 5 = centiseconds low.
  for (genvar i = 0; i < 6; i++) begin : g_sw
    sevenseg_decoder #(.ACTIVE_LOW(1'b1)) u_dig (
      .clk(clk), .rst(rst), .bcd(sw_bcd[i]), .blank(1'b0), .lamp_test(1'b0), .seg(sw_seg[i])
    );
  end

  // Names of the lit segments for each code, as one would read them off the display.
  function automatic string lit_of(input int d);
    case (d)
      0: return "abcdef";
      1: return "bc";
      2: return "abdeg";
      3: return "abcdg";
      4: return "bcfg";
      5: return "acdfg";
      6: return "acdefg";
      7: return "abc";
      8: return "abcdefg";
      9: return "abcdfg";
`ifdef SEVENSEG_HEX_DIGITS_EN
      10: return "abcefg";
      11: return "cdefg";
      12: return "adef";
      13: return "bcdeg";
      14: return "adefg";
      15: return "aefg";
`endif
      default: return "";
    endcase
  endfunction

  // Expected output: set of lit segments turned into bits, then mapped to polarity.
  function automatic logic [6:0] ref_seg(input int d, input bit bl, input bit lt, input bit al);
    string s;
    logic [6:0] lit;
    lit = 7'd0;
    if (lt) s = "abcdefg";
    else if (bl) s = "";
    else s = lit_of(d);
    for (int i = 0; i < s.len(); i++) lit[s[i] - "a"] = 1'b1;
    return al ? ~lit : lit;
  endfunction

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: seg=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_both(input string tag);
    check({tag, "_al"}, seg_al, ref_seg(bcd, blank, lamp_test, 1'b1));
    check({tag, "_ah"}, seg_ah, ref_seg(bcd, blank, lamp_test, 1'b0));
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    #1;
    check({tag, "_rst_al"}, seg_al, 7'h7F);
    check({tag, "_rst_ah"}, seg_ah, 7'h00);
    #1;
    rst = 1'b0;
  endtask

  task automatic load_time(input int t);
    int m, s, c;
    m = t / 6000;
    s = (t / 100) % 60;
    c = t % 100;
    sw_bcd[0] = 4'(m / 10);
    sw_bcd[1] = 4'(m % 10);
    sw_bcd[2] = 4'(s / 10);
    sw_bcd[3] = 4'(s % 10);
    sw_bcd[4] = 4'(c / 10);
    sw_bcd[5] = 4'(c % 10);
  endtask

  task automatic check_time(input int t);
    int m, s, c;
    int dig[6];
    m = t / 6000;
    s = (t / 100) % 60;
    c = t % 100;
    dig = '{m / 10, m % 10, s / 10, s % 10, c / 10, c % 10};
    for (int i = 0; i < 6; i++)
      check($sformatf("sw_t%0d_d%0d", t, i), sw_seg[i], ref_seg(dig[i], 1'b0, 1'b0, 1'b1));
  endtask

  initial begin
    for (int i = 0; i < 6; i++) sw_bcd[i] = 4'd0;
    step();
    step();

    // Asynchronous reset mid-cycle, then release with bcd=0.
    pulse_reset("init");
    for (int i = 0; i < 6; i++) check($sformatf("sw_rst_%0d", i), sw_seg[i], 7'h7F);
    bcd = 4'd0;
    step();
    check("rel_bcd0_al", seg_al, 7'h40);
    check("rel_bcd0_ah", seg_ah, 7'h3F);

    // Digit sweep with one-cycle lag.
    for (int d = 0; d < 10; d++) begin
      bcd = 4'(d);
      step();
      check_both($sformatf("sweep_%0d", d));
      if (d == 8) check("sweep8_lit", seg_al, 7'h00);
      if (d == 1) check("sweep1_lit", seg_al, 7'h79);
    end

    // Code 12.
    bcd = 4'd12;
    step();
`ifdef SEVENSEG_HEX_DIGITS_EN
    check("bcd12_lit", seg_al, 7'h46);
`else
    check("bcd12_lit", seg_al, 7'h7F);
`endif
    check_both("bcd12");

    // Blank, lamp test override, then back to the digit.
    bcd = 4'd5; blank = 1'b1;
    step();
    check("blank5", seg_al, 7'h7F);
    lamp_test = 1'b1;
    step();
    check("lamp5", seg_al, 7'h00);
    check("lamp5_ah", seg_ah, 7'h7F);
    blank = 1'b0; lamp_test = 1'b0;
    step();
    check("digit5", seg_al, 7'h12);

    // Randomised inputs with occasional asynchronous resets.
    for (int n = 0; n < 300; n++) begin
      bcd       = 4'($urandom_range(0, 15));
      blank     = ($urandom_range(0, 3) == 0);
      lamp_test = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) pulse_reset($sformatf("rnd%0d", n));
      step();
      check_both($sformatf("rnd%0d", n));
    end
    blank = 1'b0; lamp_test = 1'b0;

    // Stopwatch rollover 59:59.99 -> 00:00.00 across six digits.
    for (int t = 359990; t < 360010; t++) begin
      load_time(t % 360000);
      step();
      check_time(t % 360000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
